// File: rtl/pcam_timing_pkg.sv
// pcam_timing_pkg
//   Shared definitions for the pcam video timing generator.
//   - DEF_* : 1080p60 timing values (CEA-861, 148.5 MHz pixel clock)
//   - vid_beat_t : one pixel clock worth of video timing/coordinate state
//   - in_window() : half-open range test used for sync pulse decode
package pcam_timing_pkg;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic        active;
        logic        hsync;
        logic        vsync;
        logic [10:0] x;
        logic [10:0] y;
        logic        frame_start;
        logic        line_start;
    } vid_beat_t;

    localparam int VID_BEAT_W = $bits(vid_beat_t);

    // True when lo <= v < hi.
    function automatic logic in_window(input logic [31:0] v,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pcam_timing_gen_delay.sv
// pcam_delay_line
//   Fixed-depth shift register with asynchronous active-low reset to a
//   parameterised value. DEPTH = 0 turns it into a wire.
//   Ports:
//     i_clk    : clock
//     i_rst_n  : asynchronous active-low reset, loads RST_VAL into every stage
//     i_data   : WIDTH-bit input word
//     o_data   : i_data delayed by DEPTH cycles
module pcam_delay_line #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Keep at least one stage so the array is always legal; it is simply
    // left unconnected in the pass-through case.
    localparam int N_STG = (DEPTH == 0) ? 1 : DEPTH;

    logic [WIDTH-1:0] r_stage [N_STG];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_STG; k++) begin
                r_stage[k] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int k = 1; k < N_STG; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_dly
            assign o_data = r_stage[N_STG-1];
        end
    endgenerate

endmodule

// File: rtl/pcam_timing_gen.sv
// pcam_timing_gen
//   Video timing generator. A free-running h/v counter pair feeds a
//   registered fetch stage (frame-buffer read request), which is then
//   delayed by READ_LAT cycles so the video outputs line up with data
//   returned by the frame buffer.
//   Ports:
//     clk              : pixel clock
//     reset            : asynchronous active-low reset
//     en               : run enable, low holds the counters at (0,0)
//     fetch_en/x/y     : read request for the pixel that appears READ_LAT later
//     vid_active_video : VDE
//     vid_hsync/vsync  : syncs at HS_POL/VS_POL asserted level
//     x/y              : coordinates of the current video pixel
//     frame_start      : pulse on pixel (0,0)
//     line_start       : pulse on x=0 of each active line
module pcam_timing_gen
    import pcam_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        fetch_en,
    output logic [10:0] fetch_x,
    output logic [10:0] fetch_y,
    output logic        vid_active_video,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Idle beat: nothing active, both syncs at their deasserted level.
    localparam vid_beat_t RST_BEAT = '{
        active:      1'b0,
        hsync:       ~HS_POL,
        vsync:       ~VS_POL,
        x:           11'd0,
        y:           11'd0,
        frame_start: 1'b0,
        line_start:  1'b0
    };

    generate
        if (H_ACTIVE > 2048 || V_ACTIVE > 2048) begin : g_bad_active
            $error("pcam_timing_gen: active size exceeds 2048");
        end
        if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_total
            $error("pcam_timing_gen: total exceeds counter range");
        end
        if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
            $error("pcam_timing_gen: porch and sync widths must be >= 1");
        end
        if (READ_LAT < 0 || READ_LAT > 15) begin : g_bad_lat
            $error("pcam_timing_gen: READ_LAT must be 0..15");
        end
    endgenerate

    logic [11:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    vid_beat_t   w_fetch_nxt;
    vid_beat_t   r_fetch;
    vid_beat_t   w_vid;

    assign w_h_last = (r_h_cnt == 12'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 11'(V_TOTAL - 1));

    // One extra bit on the compares so a 2048-wide limit cannot alias to 0.
    assign w_active = ({1'b0, r_h_cnt} < 13'(H_ACTIVE)) &&
                      ({1'b0, r_v_cnt} < 12'(V_ACTIVE));
    assign w_hs_on  = in_window(32'(r_h_cnt), 32'(HS_START), 32'(HS_END));
    assign w_vs_on  = in_window(32'(r_v_cnt), 32'(VS_START), 32'(VS_END));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    always_comb begin
        w_fetch_nxt = RST_BEAT;
        if (en) begin
            w_fetch_nxt.active = w_active;
            w_fetch_nxt.hsync  = w_hs_on ? HS_POL : ~HS_POL;
            w_fetch_nxt.vsync  = w_vs_on ? VS_POL : ~VS_POL;
            if (w_active) begin
                w_fetch_nxt.x           = r_h_cnt[10:0];
                w_fetch_nxt.y           = r_v_cnt;
                w_fetch_nxt.frame_start = (r_h_cnt == 12'd0) && (r_v_cnt == 11'd0);
                w_fetch_nxt.line_start  = (r_h_cnt == 12'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch <= RST_BEAT;
        end else begin
            r_fetch <= w_fetch_nxt;
        end
    end

    assign fetch_en = r_fetch.active;
    assign fetch_x  = r_fetch.x;
    assign fetch_y  = r_fetch.y;

    // Delay matches the frame-buffer read latency so read data and VDE coincide.
    pcam_delay_line #(
        .WIDTH   (VID_BEAT_W),
        .DEPTH   (READ_LAT),
        .RST_VAL (RST_BEAT)
    ) u_vid_dly (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_data  (r_fetch),
        .o_data  (w_vid)
    );

    assign vid_active_video = w_vid.active;
    assign vid_hsync        = w_vid.hsync;
    assign vid_vsync        = w_vid.vsync;
    assign x                = w_vid.x;
    assign y                = w_vid.y;
    assign frame_start      = w_vid.frame_start;
    assign line_start       = w_vid.line_start;

endmodule

// File: doc/pcam_timing_gen.md
# pcam_timing_gen

Generates the video timing that pcam_decoder-style consumers expect: VDE, hsync, vsync and the matching pixel coordinates, at 1080p60 by default. It drives the frame-buffer read side in advance through a fetch port, so pixel data returned after a fixed memory read latency lines up with the delayed video outputs. It sits upstream of the video-out stage, on the pixel clock.

## Interface
- `H_ACTIVE`, 1920, active pixels per line
- `H_FP`, 88, horizontal front porch (clocks)
- `H_SYNC`, 44, hsync width (clocks)
- `H_BP`, 148, horizontal back porch (clocks)
- `V_ACTIVE`, 1080, active lines per frame
- `V_FP`, 4, vertical front porch (lines)
- `V_SYNC`, 5, vsync width (lines)
- `V_BP`, 36, vertical back porch (lines)
- `HS_POL`, 1, hsync asserted level
- `VS_POL`, 1, vsync asserted level
- `READ_LAT`, 2, cycles from fetch outputs to video outputs (0..15)
- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-low reset
- `en` in 1: run enable; low clears the counters
- `fetch_en` out 1: fetch coordinate is in the active region
- `fetch_x` out 11: column to read
- `fetch_y` out 11: row to read
- `vid_active_video` out 1: VDE
- `vid_hsync` out 1: hsync, polarity set by `HS_POL`
- `vid_vsync` out 1: vsync, polarity set by `VS_POL`
- `x` out 11: column of the current video pixel
- `y` out 11: row of the current video pixel
- `frame_start` out 1: one-cycle pulse on pixel (0,0) of the video stream
- `line_start` out 1: one-cycle pulse on pixel x=0 of every active line

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (2200); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (1125).
- Counters: `h_cnt` is 12 bits, range 0..H_TOTAL-1. `v_cnt` is 11 bits, range 0..V_TOTAL-1.
  - `h_cnt` wraps to 0 at H_TOTAL-1; `v_cnt` increments on that wrap.
  - `v_cnt` wraps to 0 when it is at V_TOTAL-1 and `h_cnt` is at H_TOTAL-1.
- Active region: `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- hsync is asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) on every line, including vertical blanking lines.
- vsync is asserted for the whole line when `v_cnt` is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). It is aligned to the line start (h_cnt=0).
- Fetch stage: registered from the counters.
  - `fetch_en` = active region.
  - `fetch_x`/`fetch_y` = counter values while `fetch_en`=1; they hold 0 otherwise.
- Video stage: {active, hsync, vsync, x, y, frame_start, line_start} are the fetch-stage values delayed by READ_LAT cycles through a shift register. With READ_LAT=0 the video stage equals the fetch stage.
- `en` low:
  - Counters are held at 0 synchronously; the fetch stage outputs inactive values (fetch_en=0, syncs deasserted, coordinates 0).
  - The delay line keeps shifting, so the video stage drains within READ_LAT cycles.
- `en` rising: counting starts at (0,0); the first fetch_en follows 1 cycle later.
- Parameter legality, checked at elaboration with `$error`:
  - H_ACTIVE ≤ 2048 and V_ACTIVE ≤ 2048.
  - H_TOTAL ≤ 4096 and V_TOTAL ≤ 2048.
  - Every porch and sync width ≥ 1.

## Timing
- Reset (`reset`=0) is asynchronous and takes effect immediately:
  - Counters and every delay-line stage are 0.
  - fetch_en, vid_active_video, frame_start, line_start = 0; fetch_x, fetch_y, x, y = 0.
  - vid_hsync = ~HS_POL and vid_vsync = ~VS_POL.
- Fetch latency: 1 cycle after the counter value. Video latency: 1+READ_LAT cycles after the counter value.
- Frame-buffer data requested on a `fetch_en` cycle must be valid exactly READ_LAT cycles later, coincident with `vid_active_video`.
- Asserting reset mid-frame aborts the frame with no partial-line completion. After release, the block behaves as if `en` had just risen.

## Structure
- Package `pcam_timing_pkg` holds:
  - the 1080p localparams: H/V active, porch and sync values, and H_TOTAL/V_TOTAL;
  - the struct `vid_beat_t` {active, hsync, vsync, x[10:0], y[10:0], frame_start, line_start}.
- Sub-module `pcam_delay_line`: parameterised width and depth, async active-low reset to a parameter reset value. When depth is 0 it is a pass-through. It carries `vid_beat_t`.

## Test plan
- Small parameter set (H 8/2/2/2, V 4/1/1/1, READ_LAT=2), release reset, en=1:
  - fetch_en first goes high 1 cycle after en, with fetch (0,0).
  - vid_active_video goes high 2 cycles later with x=0, y=0, frame_start=1, line_start=1.
- 1080p defaults, one full line:
  - exactly 1920 VDE cycles, x running 0..1919 with no gaps;
  - hsync high 44 cycles starting 88 cycles after the last active pixel;
  - line period 2200 cycles.
- Full 1080p frame:
  - 1080 lines with VDE; vsync high for lines 1084..1088;
  - period 2,475,000 cycles; y wraps 1079→0 on the next frame with a single frame_start pulse.
- en dropped at fetch (500,300), READ_LAT=2:
  - fetch_en=0 the next cycle; vid_active_video falls 2 cycles after that;
  - re-raising en restarts at (0,0) with frame_start.
- Async reset asserted mid-line:
  - all outputs take their reset values in the same cycle, without waiting for a clock edge;
  - after release with en=1, the sequence matches the first scenario.
- READ_LAT=0: video outputs equal the fetch outputs on every cycle of one small frame.
